// File: rtl/cpu_trace_pkg.sv
// cpu_trace_monitor shared types
// run states, trace entry layout and width helpers
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    HALTED    = 2'd2,
    TIMED_OUT = 2'd3
  } run_state_e;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_PC_W    = 8;
  localparam int DEF_STATE_W = 3;

  typedef struct packed {
    logic                   zf;
    logic [DEF_STATE_W-1:0] state;
    logic [DEF_PC_W-1:0]    pc;
    logic [DEF_DATA_W-1:0]  ir;
    logic [DEF_DATA_W-1:0]  a;
    logic [DEF_DATA_W-1:0]  b;
  } trace_entry_t;

  function automatic int entry_w(
    int data_w, int pc_w, int state_w
  );
    return 1 + state_w + pc_w + 3 * data_w;
  endfunction

  function automatic int off_a(int data_w);
    return data_w;
  endfunction

  function automatic int off_ir(int data_w);
    return 2 * data_w;
  endfunction

  function automatic int off_pc(int data_w);
    return 3 * data_w;
  endfunction

  function automatic int off_state(
    int data_w, int pc_w
  );
    return 3 * data_w + pc_w;
  endfunction

  function automatic int off_zf(
    int data_w, int pc_w, int state_w
  );
    return 3 * data_w + pc_w + state_w;
  endfunction

endpackage

// File: rtl/cpu_trace_monitor_if.sv
// cpu_trace_monitor sample and readout bus
// master = core/host side, slave = monitor
interface cpu_trace_monitor_if #(
  parameter int DATA_W  = 8,
  parameter int PC_W    = 8,
  parameter int STATE_W = 3
);
  import cpu_trace_pkg::*;

  localparam int ENTRY_W =
    entry_w(DATA_W, PC_W, STATE_W);

  logic               smp_valid;
  logic [PC_W-1:0]    smp_pc;
  logic [DATA_W-1:0]  smp_ir;
  logic [DATA_W-1:0]  smp_a;
  logic [DATA_W-1:0]  smp_b;
  logic               smp_zf;
  logic [STATE_W-1:0] smp_state;
  logic               halt;
  logic               rd_en;
  logic [ENTRY_W-1:0] rd_data;
  logic               rd_valid;

  modport master (
    output smp_valid, smp_pc, smp_ir,
    output smp_a, smp_b, smp_zf,
    output smp_state, halt, rd_en,
    input  rd_data, rd_valid
  );

  modport slave (
    input  smp_valid, smp_pc, smp_ir,
    input  smp_a, smp_b, smp_zf,
    input  smp_state, halt, rd_en,
    output rd_data, rd_valid
  );

endinterface

// File: rtl/trace_ring_buf.sv
// circular trace store with wrap/drop policy
// and a registered one-entry read port
module trace_ring_buf #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       init,
  input  logic                       wr_en,
  input  logic                       wrap,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             full;
  logic             empty;
  logic             we;
  logic             pop;

  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign we    = wr_en & ~init & (~full | wrap);
  assign pop   = rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (we) mem[head] <= wr_data;
  end

  // a pop issued alongside init still returns its entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= pop;
      if (pop) rd_data <= mem[tail];
      if (init) begin
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else if (wr_en) begin
        if (full) overflow <= 1'b1;
        if (we) head <= head + 1'b1;
        if (full && wrap) tail <= tail + 1'b1;
        else if (!full) count <= count + 1'b1;
      end else if (pop) begin
        tail  <= tail + 1'b1;
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_trace_monitor.sv
// cpu_8b run-control: halt/timeout FSM,
// cycle watchdog and trace capture
module cpu_trace_monitor
  import cpu_trace_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PC_W    = 8,
  parameter int STATE_W = 3,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1000,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       clear,
  input  logic                       wrap_mode,
  cpu_trace_monitor_if.slave         bus,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic [1:0]                 run_state,
  output logic [CNT_W-1:0]           cycles
);
  localparam int ENTRY_W =
    entry_w(DATA_W, PC_W, STATE_W);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LIMIT =
    CNT_W'(TIMEOUT);

  logic               rst_meta;
  logic               rst_sync;
  run_state_e         state;
  logic               wrap_q;
  logic               init;
  logic               wr;
  logic               rd;
  logic [ENTRY_W-1:0] entry;

  // assert immediately, release after two clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {rst_sync, rst_meta} <= 2'b00;
    else {rst_sync, rst_meta} <= {rst_meta, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      state  <= IDLE;
      cycles <= '0;
      wrap_q <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            cycles <= '0;
            wrap_q <= wrap_mode;
          end
        end
        RUN: begin
          if (cycles != LIMIT)
            cycles <= cycles + 1'b1;
          if (bus.halt) state <= HALTED;
          else if (cycles == LAST)
            state <= TIMED_OUT;
        end
        default: ;
      endcase
    end
  end

  assign run_state = state;
  assign init = clear | (state == IDLE & start);
  assign wr = (state == RUN) & bus.smp_valid
            & ~clear;
  assign rd = bus.rd_en & (state != RUN);
  assign entry = {
    bus.smp_zf, bus.smp_state, bus.smp_pc,
    bus.smp_ir, bus.smp_a, bus.smp_b
  };

  trace_ring_buf #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk      (clk),
    .rst_n    (rst_sync),
    .init     (init),
    .wr_en    (wr),
    .wrap     (wrap_q),
    .wr_data  (entry),
    .rd_en    (rd),
    .rd_data  (bus.rd_data),
    .rd_valid (bus.rd_valid),
    .count    (count),
    .overflow (overflow)
  );

endmodule
